// File: rtl/exec_sequencer.sv
// Sequencer that issues one instruction at a time to the green/blue/yellow units and
// hands the captured A/B/ZNC result to writeback. Optional WAIT timeout: SEQ_TIMEOUT_EN.
module exec_sequencer #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       opcode,
  output logic              green_start,
  output logic              blue_start,
  output logic              yellow_start,
  input  logic              green_done,
  input  logic              blue_done,
  input  logic              yellow_done,
  input  logic [DATA_W-1:0] A_green,
  input  logic [DATA_W-1:0] B_green,
  input  logic [DATA_W-1:0] A_blue,
  input  logic [DATA_W-1:0] B_blue,
  input  logic [DATA_W-1:0] A_yellow,
  input  logic [DATA_W-1:0] B_yellow,
  input  logic [2:0]        ZNC_green,
  input  logic [2:0]        ZNC_blue,
  input  logic [2:0]        ZNC_yellow,
  output logic [DATA_W-1:0] A_out,
  output logic [DATA_W-1:0] B_out,
  output logic [2:0]        ZNC_out,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [1:0]        unit_sel,
  output logic              busy,
  output logic              err,
  output logic [1:0]        dbg_state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Ready never depends on the partner's valid; valid holds its payload until the transfer.

  logic [1:0]        state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]        znc_q, znc_d;

  logic              is_green, is_yellow, is_blue;
  logic              sel_done;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [2:0]        sel_znc;
  logic              timed_out;

  // opcode[13:0] is decoded further downstream, not here.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^opcode[13:0];

  // Codes 01 and 10 both route to blue.
  assign is_green  = (sel_q == 2'b00);
  assign is_yellow = (sel_q == 2'b11);
  assign is_blue   = !is_green && !is_yellow;

  always_comb begin
    sel_done = green_done;
    sel_a    = A_green;
    sel_b    = B_green;
    sel_znc  = ZNC_green;
    if (is_yellow) begin
      sel_done = yellow_done;
      sel_a    = A_yellow;
      sel_b    = B_yellow;
      sel_znc  = ZNC_yellow;
    end else if (is_blue) begin
      sel_done = blue_done;
      sel_a    = A_blue;
      sel_b    = B_blue;
      sel_znc  = ZNC_blue;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ISSUE) begin
      cnt_d = 8'd0;
    end else if (state_q == S_WAIT && !sel_done && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  // Abort on the last allowed WAIT cycle, so the unit gets exactly TIMEOUT_CYCLES cycles.
  assign timed_out = (cnt_q == TO_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timed_out          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    znc_d   = znc_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          sel_d   = opcode[15:14];
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (sel_done) begin
          a_d     = sel_a;
          b_d     = sel_b;
          znc_d   = sel_znc;
          state_d = S_HOLD;
        end else if (timed_out) begin
          a_d     = '0;
          b_d     = '0;
          znc_d   = 3'b000;
          err_d   = 1'b1;
          state_d = S_HOLD;
        end
      end
      default: begin
        if (result_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 2'b00;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      znc_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      znc_q   <= znc_d;
    end
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_HOLD);
  assign green_start  = (state_q == S_ISSUE) && is_green;
  assign blue_start   = (state_q == S_ISSUE) && is_blue;
  assign yellow_start = (state_q == S_ISSUE) && is_yellow;
  assign A_out        = a_q;
  assign B_out        = b_q;
  assign ZNC_out      = znc_q;
  assign unit_sel     = sel_q;
  assign err          = err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer; the timeout scenario runs when SEQ_TIMEOUT_EN is defined.
module tb_exec_sequencer;

`ifdef SEQ_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 200;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] opcode = 16'h0000;
  logic        green_start, blue_start, yellow_start;
  logic        green_done = 1'b0, blue_done = 1'b0, yellow_done = 1'b0;
  logic [15:0] A_green = '0, B_green = '0, A_blue = '0, B_blue = '0, A_yellow = '0, B_yellow = '0;
  logic [2:0]  ZNC_green = '0, ZNC_blue = '0, ZNC_yellow = '0;
  logic [15:0] A_out, B_out;
  logic [2:0]  ZNC_out;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [1:0]  unit_sel;
  logic        busy, err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int g_starts = 0, b_starts = 0, y_starts = 0;

  exec_sequencer #(.DATA_W(16), .TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
    .green_start(green_start), .blue_start(blue_start), .yellow_start(yellow_start),
    .green_done(green_done), .blue_done(blue_done), .yellow_done(yellow_done),
    .A_green(A_green), .B_green(B_green), .A_blue(A_blue), .B_blue(B_blue),
    .A_yellow(A_yellow), .B_yellow(B_yellow),
    .ZNC_green(ZNC_green), .ZNC_blue(ZNC_blue), .ZNC_yellow(ZNC_yellow),
    .A_out(A_out), .B_out(B_out), .ZNC_out(ZNC_out),
    .result_valid(result_valid), .result_ready(result_ready),
    .unit_sel(unit_sel), .busy(busy), .err(err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: every step moves to 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (green_start)  g_starts++;
    if (blue_start)   b_starts++;
    if (yellow_start) y_starts++;
  endtask

  task automatic issue(input logic [15:0] op);
    instr_valid = 1'b1;
    opcode      = op;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_instr_ready got %b exp 1", instr_ready); end
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_flags got busy=%b rv=%b err=%b exp 0", busy, result_valid, err); end
    checks++; if (A_out !== 16'h0 || B_out !== 16'h0 || ZNC_out !== 3'b0 || unit_sel !== 2'b0) begin errors++; $display("FAIL rst_data got %h %h %b %b exp 0", A_out, B_out, ZNC_out, unit_sel); end
    checks++; if ({green_start, blue_start, yellow_start} !== 3'b000) begin errors++; $display("FAIL rst_starts got %b exp 000", {green_start, blue_start, yellow_start}); end
    #10 rst_n = 1'b1;
    tick();
    checks++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rel_idle got ready=%b busy=%b exp 1/0", instr_ready, busy); end
  endtask

  task automatic test_green();
    g_starts = 0; b_starts = 0; y_starts = 0;
    issue(16'h0000);
    checks++; if ({green_start, blue_start, yellow_start} !== 3'b100) begin errors++; $display("FAIL green_issue_starts got %b exp 100", {green_start, blue_start, yellow_start}); end
    checks++; if (unit_sel !== 2'd0 || busy !== 1'b1 || instr_ready !== 1'b0) begin errors++; $display("FAIL green_issue_state got sel=%0d busy=%b rdy=%b exp 0/1/0", unit_sel, busy, instr_ready); end
    blue_done = 1'b1; yellow_done = 1'b1; A_blue = 16'hDEAD;
    tick(); tick(); tick();
    checks++; if (result_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL green_ignore_other_done got rv=%b busy=%b exp 0/1", result_valid, busy); end
    blue_done = 1'b0; yellow_done = 1'b0;
    A_green = 16'h1234; B_green = 16'h0001; ZNC_green = 3'b010; green_done = 1'b1;
    tick();
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL green_rv got %b exp 1", result_valid); end
    checks++; if (A_out !== 16'h1234 || B_out !== 16'h0001 || ZNC_out !== 3'b010) begin errors++; $display("FAIL green_data got %h %h %b exp 1234 0001 010", A_out, B_out, ZNC_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL green_err got %b exp 0", err); end
    green_done = 1'b0; A_green = 16'hFFFF;
    tick();
    checks++; if (result_valid !== 1'b1 || A_out !== 16'h1234) begin errors++; $display("FAIL green_hold_stable got rv=%b A=%h exp 1/1234", result_valid, A_out); end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checks++; if (result_valid !== 1'b0 || instr_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL green_release got rv=%b rdy=%b busy=%b exp 0/1/0", result_valid, instr_ready, busy); end
    checks++; if (A_out !== 16'h1234) begin errors++; $display("FAIL green_retain got %h exp 1234", A_out); end
    checks++; if (g_starts != 1 || b_starts != 0 || y_starts != 0) begin errors++; $display("FAIL green_start_count got %0d/%0d/%0d exp 1/0/0", g_starts, b_starts, y_starts); end
  endtask

  task automatic test_blue_alias();
    logic [15:0] ops [2];
    ops[0] = 16'h4000; ops[1] = 16'h8000;
    g_starts = 0; b_starts = 0; y_starts = 0;
    for (int i = 0; i < 2; i++) begin
      issue(ops[i]);
      checks++; if ({green_start, blue_start, yellow_start} !== 3'b010) begin errors++; $display("FAIL blue_starts[%0d] got %b exp 010", i, {green_start, blue_start, yellow_start}); end
      checks++; if (unit_sel !== 2'(i + 1)) begin errors++; $display("FAIL blue_sel[%0d] got %0d exp %0d", i, unit_sel, i + 1); end
      green_done = 1'b1; yellow_done = 1'b1;
      tick(); tick();
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL blue_ignore[%0d] got rv=%b exp 0", i, result_valid); end
      blue_done = 1'b1; A_blue = 16'hBEEF; B_blue = 16'(i + 5); ZNC_blue = 3'b100;
      tick();
      checks++; if (result_valid !== 1'b1 || A_out !== 16'hBEEF || B_out !== 16'(i + 5) || ZNC_out !== 3'b100) begin errors++; $display("FAIL blue_data[%0d] got rv=%b %h %h %b exp 1 beef %h 100", i, result_valid, A_out, B_out, ZNC_out, 16'(i + 5)); end
      green_done = 1'b0; yellow_done = 1'b0; blue_done = 1'b0;
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
    end
    checks++; if (g_starts != 0 || b_starts != 2 || y_starts != 0) begin errors++; $display("FAIL blue_start_count got %0d/%0d/%0d exp 0/2/0", g_starts, b_starts, y_starts); end
  endtask

  task automatic test_backpressure();
    issue(16'hC000);
    checks++; if ({green_start, blue_start, yellow_start} !== 3'b001 || unit_sel !== 2'd3) begin errors++; $display("FAIL bp_issue got starts=%b sel=%0d exp 001/3", {green_start, blue_start, yellow_start}, unit_sel); end
    A_yellow = 16'hCAFE; B_yellow = 16'h5555; ZNC_yellow = 3'b001; yellow_done = 1'b1;
    tick();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL bp_issue_done_ignored got rv=%b exp 0", result_valid); end
    tick();
    checks++; if (result_valid !== 1'b1 || A_out !== 16'hCAFE) begin errors++; $display("FAIL bp_min_latency got rv=%b A=%h exp 1/cafe", result_valid, A_out); end
    yellow_done = 1'b0; A_yellow = 16'h0000; B_yellow = 16'h0000;
    instr_valid = 1'b1; opcode = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (result_valid !== 1'b1 || A_out !== 16'hCAFE || B_out !== 16'h5555 || ZNC_out !== 3'b001) begin errors++; $display("FAIL bp_stable[%0d] got rv=%b %h %h %b exp 1 cafe 5555 001", i, result_valid, A_out, B_out, ZNC_out); end
      checks++; if (instr_ready !== 1'b0 || green_start !== 1'b0) begin errors++; $display("FAIL bp_no_accept[%0d] got rdy=%b gs=%b exp 0/0", i, instr_ready, green_start); end
    end
    result_ready = 1'b1;
    tick();
    checks++; if (result_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL bp_release got rv=%b rdy=%b exp 0/1", result_valid, instr_ready); end
    tick();
    instr_valid = 1'b0;
    checks++; if (green_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept got gs=%b busy=%b exp 1/1", green_start, busy); end
    tick();
    A_green = 16'h0007; green_done = 1'b1;
    tick();
    green_done = 1'b0;
    checks++; if (result_valid !== 1'b1 || A_out !== 16'h0007) begin errors++; $display("FAIL bp_fast_result got rv=%b A=%h exp 1/0007", result_valid, A_out); end
    tick();
    checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_single_rv_cycle got rv=%b busy=%b exp 0/0", result_valid, busy); end
    result_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    issue(16'h0000);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_flags got busy=%b rv=%b rdy=%b exp 0/0/1", busy, result_valid, instr_ready); end
    checks++; if (A_out !== 16'h0 || B_out !== 16'h0 || ZNC_out !== 3'b0 || unit_sel !== 2'b0) begin errors++; $display("FAIL rst_wait_data got %h %h %b %b exp 0", A_out, B_out, ZNC_out, unit_sel); end
    #2 rst_n = 1'b1;
    A_green = 16'h0009; green_done = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || A_out !== 16'h0) begin errors++; $display("FAIL rst_late_done got busy=%b rv=%b A=%h exp 0/0/0", busy, result_valid, A_out); end
    green_done = 1'b0;
    issue(16'hC000);
    checks++; if (yellow_start !== 1'b1) begin errors++; $display("FAIL rst_issue_pre got ys=%b exp 1", yellow_start); end
    rst_n = 1'b0;
    #1;
    checks++; if (yellow_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_issue_drop got ys=%b busy=%b exp 0/0", yellow_start, busy); end
    #2 rst_n = 1'b1;
    tick();
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    A_blue = 16'h1111; B_blue = 16'h2222; ZNC_blue = 3'b111;
    issue(16'h4000);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL to_wait[%0d] got rv=%b exp 0", i, result_valid); end
    end
    tick();
    checks++; if (result_valid !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL to_abort got rv=%b err=%b exp 1/1", result_valid, err); end
    checks++; if (A_out !== 16'h0 || B_out !== 16'h0 || ZNC_out !== 3'b0) begin errors++; $display("FAIL to_zero got %h %h %b exp 0", A_out, B_out, ZNC_out); end
    blue_done = 1'b1; result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL to_late_done got busy=%b rv=%b exp 0/0", busy, result_valid); end
    blue_done = 1'b0;
    issue(16'h0000);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_clear got %b exp 0", err); end
    tick();
    green_done = 1'b1;
    tick();
    green_done = 1'b0; result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    issue(16'h0000);
    for (int i = 0; i < 30; i++) tick();
    checks++; if (busy !== 1'b1 || result_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL nto_wait got busy=%b rv=%b err=%b exp 1/0/0", busy, result_valid, err); end
    A_green = 16'h00AA; green_done = 1'b1;
    tick();
    green_done = 1'b0;
    checks++; if (result_valid !== 1'b1 || A_out !== 16'h00AA || err !== 1'b0) begin errors++; $display("FAIL nto_result got rv=%b A=%h err=%b exp 1/00aa/0", result_valid, A_out, err); end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_green();
    test_blue_alias();
    test_backpressure();
    test_reset_mid_op();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
